// File: rtl/gc_responder.sv
// Game-controller command responder.
// Decodes ID / RESET / ORIGINS / STATUS commands from a bit detector, waits a
// turnaround delay, then streams the reply MSB first through a bit generator
// with a strict launch/busy handshake. Status bytes are fetched one at a time
// from an external store just before they are transmitted.
module gc_responder #(
    parameter logic [23:0] CONTROLLER_ID = 24'h090000,
    parameter logic [79:0] CALIBRATION   = 80'h00808080808000000202,
    parameter int          STATE_BYTES   = 8,
    parameter int          RESP_DELAY    = 200,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_start,
    input  logic       rx_stop,
    input  logic       rx_error,
    input  logic       rx_strobe,
    input  logic       rx_data,
    input  logic       tx_busy,
    output logic       tx_strobe,
    output logic       tx_data,
    output logic       tx_stop,
    output logic [3:0] state_addr,
    output logic       state_request,
    input  logic [7:0] state_data,
    input  logic       state_ack,
    output logic       rumble,
    output logic       cmd_done,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_DELAY, S_FETCH, S_SEND, S_STOP
    } state_t;

    // Launch handshake: after a launch the generator must go busy then idle.
    typedef enum logic [1:0] {
        HS_READY, HS_WAIT_HI, HS_WAIT_LO
    } hs_t;

    typedef enum logic [1:0] {
        REP_ID, REP_ORG, REP_STAT
    } reply_t;

    localparam logic [7:0]  ID_CODE    = 8'h00;
    localparam logic [7:0]  RST_CODE   = 8'hFF;
    localparam logic [7:0]  ORG_CODE   = 8'h41;
    localparam logic [15:0] STAT_PFX   = 16'h4003;
    localparam logic [15:0] DELAY_LAST = 16'(RESP_DELAY - 2);
    localparam logic [15:0] TO_LAST    = 16'(FETCH_TIMEOUT - 1);
    localparam logic [3:0]  LAST_ADDR  = 4'(STATE_BYTES - 1);

    state_t      state_reg, state_next;
    hs_t         hs_reg;
    reply_t      reply_reg;
    logic [6:0]  bit_count_reg;
    logic        id_flag_reg, rst_flag_reg, org_flag_reg, stat_flag_reg;
    logic        last_bit_reg;
    logic [15:0] delay_cnt_reg;
    logic [15:0] fetch_cnt_reg;
    logic [79:0] shift_reg;
    logic [6:0]  bits_left_reg;
    logic [3:0]  state_addr_reg;
    logic        state_request_reg;
    logic        rumble_reg;
    logic        fault_reg;

    logic rx_accept, len8, sel_id, sel_org, sel_stat;
    logic delay_done, ack_ok, fetch_to, launch, last_bit, last_byte;

    // A stop only counts in RX when not overridden by an error or restart.
    assign rx_accept  = (state_reg == S_RX) && rx_stop && !rx_error && !rx_start;
    assign len8       = (bit_count_reg == 7'd8);
    assign sel_id     = rx_accept && len8 && (id_flag_reg || rst_flag_reg);
    assign sel_org    = rx_accept && len8 && org_flag_reg && !sel_id;
    assign sel_stat   = rx_accept && (bit_count_reg == 7'd24) && stat_flag_reg;
    assign delay_done = (delay_cnt_reg == DELAY_LAST);
    assign ack_ok     = (state_reg == S_FETCH) && state_request_reg && state_ack;
    assign fetch_to   = (state_reg == S_FETCH) && state_request_reg && !state_ack
                        && (fetch_cnt_reg == TO_LAST);
    assign launch     = ((state_reg == S_SEND) || (state_reg == S_STOP))
                        && (hs_reg == HS_READY) && !tx_busy;
    assign last_bit   = (bits_left_reg == 7'd1);
    assign last_byte  = (state_addr_reg == LAST_ADDR);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (rx_start) state_next = S_RX;
            S_RX: begin
                if (rx_error)      state_next = S_IDLE;
                else if (rx_start) state_next = S_RX;
                else if (rx_stop)  state_next = (sel_id || sel_org || sel_stat) ? S_DELAY : S_IDLE;
            end
            S_DELAY: begin
                if (rx_error)        state_next = S_IDLE;
                else if (delay_done) state_next = (reply_reg == REP_STAT) ? S_FETCH : S_SEND;
            end
            S_FETCH: begin
                if (ack_ok)        state_next = S_SEND;
                else if (fetch_to) state_next = S_IDLE;
            end
            S_SEND: begin
                if (launch && last_bit)
                    state_next = (reply_reg == REP_STAT && !last_byte) ? S_FETCH : S_STOP;
            end
            S_STOP:  if (launch) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Launch outputs; data and stop flag are valid alongside the strobe.
    always_comb begin
        tx_strobe = launch;
        tx_stop   = (state_reg == S_STOP);
        tx_data   = 1'b0;
        cmd_done  = launch && (state_reg == S_STOP);
        if (state_reg == S_STOP)      tx_data = 1'b1;
        else if (state_reg == S_SEND) tx_data = shift_reg[79];
    end

    // Command receiver: bit counter, match flags, rumble capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_count_reg <= 7'd0;
            id_flag_reg   <= 1'b1;
            rst_flag_reg  <= 1'b1;
            org_flag_reg  <= 1'b1;
            stat_flag_reg <= 1'b1;
            last_bit_reg  <= 1'b0;
            reply_reg     <= REP_ID;
            rumble_reg    <= 1'b0;
        end else if (state_reg == S_IDLE || state_reg == S_RX) begin
            if (rx_start) begin
                bit_count_reg <= 7'd0;
                id_flag_reg   <= 1'b1;
                rst_flag_reg  <= 1'b1;
                org_flag_reg  <= 1'b1;
                stat_flag_reg <= 1'b1;
            end else begin
                if (rx_strobe && state_reg == S_RX) begin
                    if (bit_count_reg != 7'd127)
                        bit_count_reg <= bit_count_reg + 7'd1;
                    if (bit_count_reg < 7'd8) begin
                        id_flag_reg  <= id_flag_reg  & (rx_data == ID_CODE[~bit_count_reg[2:0]]);
                        rst_flag_reg <= rst_flag_reg & (rx_data == RST_CODE[~bit_count_reg[2:0]]);
                        org_flag_reg <= org_flag_reg & (rx_data == ORG_CODE[~bit_count_reg[2:0]]);
                    end
                    if (bit_count_reg < 7'd16)
                        stat_flag_reg <= stat_flag_reg & (rx_data == STAT_PFX[~bit_count_reg[3:0]]);
                    last_bit_reg <= rx_data;
                end
                if (rx_error) begin
                    id_flag_reg   <= 1'b0;
                    rst_flag_reg  <= 1'b0;
                    org_flag_reg  <= 1'b0;
                    stat_flag_reg <= 1'b0;
                end
            end
            if (sel_id)   reply_reg <= REP_ID;
            if (sel_org)  reply_reg <= REP_ORG;
            if (sel_stat) reply_reg <= REP_STAT;
            if (sel_stat)
                rumble_reg <= last_bit_reg;
            else if (rx_accept && len8 && rst_flag_reg)
                rumble_reg <= 1'b0;
        end
    end

    // Reply datapath: turnaround delay, status fetch, bit shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay_cnt_reg     <= 16'd0;
            fetch_cnt_reg     <= 16'd0;
            shift_reg         <= 80'd0;
            bits_left_reg     <= 7'd0;
            state_addr_reg    <= 4'd0;
            state_request_reg <= 1'b0;
            fault_reg         <= 1'b0;
        end else begin
            fault_reg <= 1'b0;
            if (rx_accept)
                delay_cnt_reg <= 16'd0;
            else if (state_reg == S_DELAY)
                delay_cnt_reg <= delay_cnt_reg + 16'd1;

            if (state_reg != S_FETCH && state_next == S_FETCH) begin
                state_request_reg <= 1'b1;
                fetch_cnt_reg     <= 16'd0;
                state_addr_reg    <= (state_reg == S_DELAY) ? 4'd0 : state_addr_reg + 4'd1;
            end

            if (state_reg == S_FETCH && state_request_reg) begin
                if (state_ack) begin
                    shift_reg         <= {state_data, 72'd0};
                    bits_left_reg     <= 7'd8;
                    state_request_reg <= 1'b0;
                end else if (fetch_to) begin
                    state_request_reg <= 1'b0;
                    fault_reg         <= 1'b1;
                end else begin
                    fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
                end
            end

            if (state_reg == S_DELAY && state_next == S_SEND) begin
                if (reply_reg == REP_ORG) begin
                    shift_reg     <= CALIBRATION;
                    bits_left_reg <= 7'd80;
                end else begin
                    shift_reg     <= {CONTROLLER_ID, 56'd0};
                    bits_left_reg <= 7'd24;
                end
            end

            if (state_reg == S_SEND && launch) begin
                shift_reg     <= {shift_reg[78:0], 1'b0};
                bits_left_reg <= bits_left_reg - 7'd1;
            end
        end
    end

    // Handshake tracker: a launch re-arms only after busy rises and falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_reg <= HS_READY;
        end else if (launch) begin
            hs_reg <= HS_WAIT_HI;
        end else begin
            case (hs_reg)
                HS_WAIT_HI: if (tx_busy)  hs_reg <= HS_WAIT_LO;
                HS_WAIT_LO: if (!tx_busy) hs_reg <= HS_READY;
                default:    hs_reg <= HS_READY;
            endcase
        end
    end

    assign state_addr    = state_addr_reg;
    assign state_request = state_request_reg;
    assign rumble        = rumble_reg;
    assign fault         = fault_reg;

endmodule

// File: doc/gc_responder.md
GC_RESPONDER -- requirements
Module: gc_responder

Interface
REQ-001 SHALL have parameter CONTROLLER_ID, default 24'h090000, the 3-byte reply to ID and reset commands.
REQ-002 SHALL have parameter CALIBRATION, default 80'h00808080808000000202, the 10-byte origins reply, MSB first.
REQ-003 SHALL have parameter STATE_BYTES, default 8, the number of status bytes (1-16) fetched and sent per poll.
REQ-004 SHALL have parameter RESP_DELAY, default 200, the number of clk cycles from rx_stop to the first tx_strobe.
REQ-005 SHALL have parameter FETCH_TIMEOUT, default 255, the maximum cycles to wait for state_ack.
REQ-006 clk  input  1  system clock; reset  input  1  reset, asynchronous, active-high.
REQ-007 rx_start, rx_stop, rx_error, rx_strobe, rx_data  input  1 each  bit-detector events and the received bit value.
REQ-008 tx_busy  input  1  bit generator is busy; tx_strobe  output  1  one-cycle bit launch; tx_data  output  1  bit value; tx_stop  output  1  marks the launch as a stop bit.
REQ-009 state_addr  output  4  status byte index; state_request  output  1  fetch request; state_data  input  8  fetched byte; state_ack  input  1  one-cycle data-valid strobe.
REQ-010 rumble  output  1  latched rumble flag; cmd_done  output  1  one-cycle pulse at end of a reply; fault  output  1  one-cycle pulse on fetch timeout.

Function
REQ-011 SHALL count received bits in a 7-bit counter: cleared on rx_start, incremented on rx_strobe, saturating at 127.
REQ-012 SHALL track four match flags (ID 0x00, RESET 0xFF, ORIGINS 0x41, STATUS 0x4003XX):
- all flags set on rx_start;
- a flag clears on any mismatching bit (MSB first) and stays cleared until the next rx_start.
REQ-013 On rx_stop, exactly one of the following SHALL select a reply:
- bit_count==8 with the ID or RESET flag set -> ID reply;
- bit_count==8 with the ORIGINS flag set -> origins reply;
- bit_count==24 with the STATUS flag set -> status reply.
Any other rx_stop SHALL return to IDLE with no reply.
REQ-014 On a STATUS match, received bit 23 SHALL be latched into rumble at rx_stop; a RESET match SHALL clear rumble.
REQ-015 rx_error SHALL clear all match flags; in RX or DELAY it SHALL force IDLE.
REQ-016 FSM states SHALL be IDLE, RX, DELAY, FETCH, SEND, STOP, with these transitions:
- IDLE->RX on rx_start;
- RX->DELAY on a valid rx_stop;
- DELAY->FETCH (status reply) or SEND (other replies) after RESP_DELAY cycles;
- SEND->FETCH at each status byte boundary;
- SEND->STOP after the last bit;
- STOP->IDLE after the stop-bit launch.
REQ-017 Launch handshake: tx_strobe SHALL assert for exactly one cycle, only while tx_busy is low, with tx_data and tx_stop valid in that same cycle.
REQ-018 No second launch SHALL occur until tx_busy has been seen high and then low again.
REQ-019 Reply bits SHALL go MSB first: 24 bits for ID, 80 bits for origins, STATE_BYTES*8 bits for status, followed by one launch with tx_stop=1 and tx_data=1.
REQ-020 Status fetch sequence: set state_addr to the byte index (0 up to STATE_BYTES-1), hold state_request high until state_ack, capture state_data on the ack cycle, and drop state_request the next cycle.
REQ-021 Fetch of byte N+1 SHALL complete before its first bit is launched; no gap beyond the fetch latency is permitted.
REQ-022 If state_ack is absent FETCH_TIMEOUT cycles after state_request rises, the block SHALL abort the reply: no stop bit, fault pulse, go to IDLE.
REQ-023 rx_start/rx_strobe/rx_stop received during DELAY, FETCH, SEND or STOP SHALL be ignored (half duplex).
REQ-024 cmd_done SHALL pulse in the cycle the stop bit is launched.
REQ-025 state_ack arriving with state_request low SHALL be ignored.

Reset
REQ-026 On reset the block SHALL be in IDLE with:
- tx_strobe, tx_data, tx_stop, state_request, rumble, cmd_done, fault = 0;
- state_addr = 0, bit counter = 0, all match flags = 1.
REQ-027 Reset asserted mid-reply SHALL abort immediately with no further launches; after release the block SHALL wait for a fresh rx_start.

Verification
REQ-028 Bits 0x00 then rx_stop -> after 200 cycles: 24 launches 0x090000, then a stop launch, then a cmd_done pulse.
REQ-029 Bits 0x400301 with memory bytes 0x00..0x07 -> rumble=1; state_addr steps 0..7; 64 bits 0001020304050607 then stop.
REQ-030 Bits 0x41 -> 80 launches 0x00808080808000000202 then stop; bits 0x42 -> no launch, IDLE.
REQ-031 Status poll with state_ack withheld at byte 3 -> 24 bits sent, fault pulse 255 cycles after the request, no stop bit, IDLE.
REQ-032 rx_error after 4 bits of 0x00 -> no reply; 0xFF after a rumble=1 poll -> ID reply and rumble=0.
REQ-033 Reset pulse during bit 10 of an origins reply -> all outputs at reset values; the next 0x00 command is answered normally.
